// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pulls bytes from an upstream buffer.
// A byte is fetched with a single read strobe, latched one cycle later,
// and sent LSB first as a start bit, d_width data bits and a stop bit.
module uart_tx_fifo_reader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int d_width      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               fifo_empty,
   input  logic [d_width-1:0] fifo_data,
   output logic               fifo_rd,
   output logic               tx,
   output logic               busy,
   output logic               tx_done
);

   localparam int IDX_W = $clog2(d_width + 1);
   localparam logic [15:0]      LAST_CNT = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0]      DONE_CNT = 16'(CLKS_PER_BIT - 2);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(d_width - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      START,
      DATA,
      STOP
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        baud_q, baud_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [d_width-1:0] shift_q, shift_d;
   logic [d_width-1:0] shifted;
   logic               tx_q, tx_d;
   logic               rd_q, rd_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               bit_end;

   // The only counter value that ends a bit period is the last one.
   assign bit_end = (baud_q == LAST_CNT);

   // Next-state logic; every output is computed here and registered below.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      rd_d    = 1'b0;
      done_d  = 1'b0;
      shifted = shift_q >> 1;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (en && !fifo_empty) begin
               state_d = FETCH;
               rd_d    = 1'b1;
            end
         end
         FETCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            shift_d = fifo_data;
            tx_d    = 1'b0;
            baud_d  = 16'd0;
            state_d = START;
         end
         START: begin
            if (bit_end) begin
               baud_d  = 16'd0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d  = 16'd0;
               shift_d = shifted;
               if (idx_q == LAST_BIT) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  tx_d  = shifted[0];
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (baud_q == DONE_CNT) begin
               done_d = 1'b1;
            end
            if (bit_end) begin
               baud_d  = 16'd0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset; reset drops any frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= 16'd0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign fifo_rd = rd_q;
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Testbench for uart_tx_fifo_reader with an upstream buffer model and a
// cycle-level reference of the expected line/strobe/busy/done waveforms.
module tb_uart_tx_fifo_reader;

   localparam int C     = 4;
   localparam int W     = 8;
   localparam int FRAME = (W + 2) * C;
   localparam int MAXC  = 256;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic [7:0] fifo_q[$];
   logic [7:0] model_bytes[$];
   logic [3:0] log_v[MAXC];
   logic [3:0] exp_v[MAXC];
   int         log_n      = 0;
   int         checks     = 0;
   int         passes     = 0;
   int         underflows = 0;
   bit         toggle_mode = 1'b0;

   uart_tx_fifo_reader #(
      .CLKS_PER_BIT(C),
      .d_width     (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_rd   (fifo_rd),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Line level k cycles into a frame carrying byte b.
   function automatic logic frame_bit(logic [7:0] b, int k);
      int slot;
      slot = k / C;
      if (slot == 0) return 1'b0;
      if (slot <= W) return b[slot-1];
      return 1'b1;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      fifo_empty = 1'b0;
   endtask

   // Log {tx,rd,busy,done} for the current cycle, advance one clock, then
   // let the upstream buffer answer a read strobe seen in the logged cycle.
   task automatic tick();
      logic rd_prev;
      if (log_n < MAXC) begin
         log_v[log_n] = {tx, fifo_rd, busy, tx_done};
         log_n++;
      end
      rd_prev = fifo_rd;
      @(posedge clk);
      #1;
      if (rd_prev) begin
         if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
         else underflows++;
      end else if (toggle_mode) begin
         fifo_data = 8'($urandom);
      end
      fifo_empty = (fifo_q.size() == 0);
   endtask

   // Expected waveform with en held high from cycle 0: frame i reads at
   // 1+i*(FRAME+3), the line falls two cycles later, done ends the stop bit.
   task automatic build_model(input int n);
      int s0;
      for (int c = 0; c < n; c++) exp_v[c] = 4'b1000;
      foreach (model_bytes[i]) begin
         s0 = 1 + i * (FRAME + 3);
         if (s0 + FRAME + 1 < n) begin
            exp_v[s0][2] = 1'b1;
            for (int c = s0; c <= s0 + FRAME + 1; c++) exp_v[c][1] = 1'b1;
            exp_v[s0 + FRAME + 1][0] = 1'b1;
            for (int k = 0; k < FRAME; k++) exp_v[s0 + 2 + k][3] = frame_bit(model_bytes[i], k);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      push_byte(8'h12);
      log_n = 0;
      for (int i = 0; i < 6; i++) tick();
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (log_v[c] !== 4'b1000)
            $display("[TB] FAIL reset_hold cycle %0d: tx/rd/busy/done=%b required 1000", c, log_v[c]);
         else passes++;
      end
      en = 1'b0;
      fifo_q.delete();
      fifo_empty = 1'b1;
      rst = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_single_frame();
      int rd_cnt;
      push_byte(8'h55);
      model_bytes.delete();
      model_bytes.push_back(8'h55);
      en = 1'b1;
      log_n = 0;
      for (int i = 0; i < 50; i++) tick();
      en = 1'b0;
      build_model(50);
      rd_cnt = 0;
      for (int c = 0; c < 50; c++) begin
         rd_cnt += int'(log_v[c][2]);
         checks++;
         if (log_v[c] !== exp_v[c])
            $display("[TB] FAIL single_frame cycle %0d: tx/rd/busy/done=%b required %b", c, log_v[c], exp_v[c]);
         else passes++;
      end
      checks++;
      if (rd_cnt !== 1) $display("[TB] FAIL single_frame_rd_count: %0d required 1", rd_cnt);
      else passes++;
   endtask

   task automatic test_two_frames();
      int rd_cnt;
      underflows = 0;
      push_byte(8'hA3);
      push_byte(8'h0F);
      model_bytes.delete();
      model_bytes.push_back(8'hA3);
      model_bytes.push_back(8'h0F);
      en = 1'b1;
      log_n = 0;
      for (int i = 0; i < 100; i++) tick();
      build_model(100);
      rd_cnt = 0;
      for (int c = 0; c < 100; c++) begin
         rd_cnt += int'(log_v[c][2]);
         checks++;
         if (log_v[c] !== exp_v[c])
            $display("[TB] FAIL two_frames cycle %0d: tx/rd/busy/done=%b required %b", c, log_v[c], exp_v[c]);
         else passes++;
      end
      checks++;
      if (rd_cnt !== 2) $display("[TB] FAIL two_frames_rd_count: %0d required 2", rd_cnt);
      else passes++;
      checks++;
      if (underflows !== 0) $display("[TB] FAIL two_frames_underflow: %0d required 0", underflows);
      else passes++;
      en = 1'b0;
   endtask

   task automatic test_empty();
      underflows = 0;
      en = 1'b1;
      log_n = 0;
      for (int i = 0; i < 100; i++) tick();
      for (int c = 0; c < 100; c++) begin
         checks++;
         if (log_v[c] !== 4'b1000)
            $display("[TB] FAIL empty_idle cycle %0d: tx/rd/busy/done=%b required 1000", c, log_v[c]);
         else passes++;
      end
      checks++;
      if (underflows !== 0) $display("[TB] FAIL empty_underflow: %0d required 0", underflows);
      else passes++;
      en = 1'b0;
   endtask

   task automatic test_en_drop();
      push_byte(8'h81);
      push_byte(8'h33);
      model_bytes.delete();
      model_bytes.push_back(8'h81);
      en = 1'b1;
      log_n = 0;
      for (int i = 0; i < 4; i++) tick();
      en = 1'b0;
      for (int i = 0; i < 56; i++) tick();
      build_model(60);
      for (int c = 0; c < 60; c++) begin
         checks++;
         if (log_v[c] !== exp_v[c])
            $display("[TB] FAIL en_drop cycle %0d: tx/rd/busy/done=%b required %b", c, log_v[c], exp_v[c]);
         else passes++;
      end
      fifo_q.delete();
      fifo_empty = 1'b1;
   endtask

   task automatic test_mid_frame_reset();
      int rd_cnt;
      int done_cnt;
      push_byte(8'hFF);
      push_byte(8'hFF);
      en = 1'b1;
      log_n = 0;
      for (int i = 0; i < 16; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 53; i++) tick();
      en = 1'b0;
      checks++;
      if (log_v[17] !== 4'b1000)
         $display("[TB] FAIL reset_abandon: tx/rd/busy/done=%b required 1000", log_v[17]);
      else passes++;
      checks++;
      if (log_v[18][2] !== 1'b1) $display("[TB] FAIL reset_refetch: rd=%b required 1", log_v[18][2]);
      else passes++;
      rd_cnt = 0;
      done_cnt = 0;
      for (int c = 0; c < 70; c++) rd_cnt += int'(log_v[c][2]);
      for (int c = 0; c < 59; c++) done_cnt += int'(log_v[c][0]);
      checks++;
      if (rd_cnt !== 2) $display("[TB] FAIL reset_rd_count: %0d required 2", rd_cnt);
      else passes++;
      checks++;
      if (done_cnt !== 0) $display("[TB] FAIL reset_no_done: %0d required 0", done_cnt);
      else passes++;
      checks++;
      if (log_v[59][0] !== 1'b1) $display("[TB] FAIL reset_second_done: %b required 1", log_v[59][0]);
      else passes++;
      checks++;
      if (log_v[20][3] !== 1'b0) $display("[TB] FAIL reset_second_start: tx=%b required 0", log_v[20][3]);
      else passes++;
      for (int b = 0; b < W; b++) begin
         checks++;
         if (log_v[20 + C * (1 + b)][3] !== 1'b1)
            $display("[TB] FAIL reset_second_bit%0d: tx=%b required 1", b, log_v[20 + C * (1 + b)][3]);
         else passes++;
      end
   endtask

   task automatic test_data_toggle();
      logic [7:0] b;
      toggle_mode = 1'b1;
      model_bytes.delete();
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         push_byte(b);
         model_bytes.push_back(b);
      end
      en = 1'b1;
      log_n = 0;
      for (int i = 0; i < 140; i++) tick();
      en = 1'b0;
      toggle_mode = 1'b0;
      build_model(140);
      for (int c = 0; c < 140; c++) begin
         checks++;
         if (log_v[c] !== exp_v[c])
            $display("[TB] FAIL data_toggle cycle %0d: tx/rd/busy/done=%b required %b", c, log_v[c], exp_v[c]);
         else passes++;
      end
   endtask

   // Scenario sequence.
   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
      tick();
      tick();
      test_reset();
      test_single_frame();
      test_two_frames();
      test_empty();
      test_en_drop();
      test_mid_frame_reset();
      test_data_toggle();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 SHALL provide parameters, one per line:
- CLKS_PER_BIT, 868, clock cycles per serial bit (legal 2..65535)
- d_width, 8, data bits per frame and width of fifo_data
REQ-002 SHALL use a single clock and a synchronous, active-high reset.
REQ-003 SHALL provide these ports, one per line:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  transmit enable; sampled only in IDLE
- fifo_empty  in  1  upstream buffer empty flag
- fifo_data  in  d_width  upstream buffer read data, valid from the cycle after a fifo_rd pulse
- fifo_rd  out  1  registered single-cycle read-strobe pulse to the upstream buffer
- tx  out  1  serial line, idle high
- busy  out  1  high whenever state is not IDLE
- tx_done  out  1  one-cycle pulse at the end of each stop bit

Function
REQ-004 SHALL implement the FSM states IDLE, FETCH, WAIT, START, DATA and STOP, all held in registers.
REQ-005 IDLE: when en=1 and fifo_empty=0, SHALL move to FETCH and set fifo_rd=1 at the same edge; otherwise SHALL stay in IDLE.
REQ-006 FETCH: SHALL last exactly 1 cycle with fifo_rd=1, then move to WAIT with fifo_rd=0.
REQ-007 fifo_rd SHALL never be high for 2 consecutive cycles, and SHALL be low for at least 1 cycle between pulses, because the upstream buffer is edge-triggered on its read strobe.
REQ-008 WAIT: SHALL last 1 cycle, then at the exiting edge:
- latch fifo_data into a d_width shift register
- set tx=0
- clear the baud counter
- move to START
REQ-009 START: SHALL hold tx=0 for exactly CLKS_PER_BIT cycles, then move to DATA with bit index 0.
REQ-010 DATA: SHALL drive shift-register bit 0 (LSB first) for CLKS_PER_BIT cycles per bit, shift right after each bit, and move to STOP after d_width bits.
REQ-011 STOP: SHALL hold tx=1 for CLKS_PER_BIT cycles, pulse tx_done for 1 cycle on the final stop cycle, then return to IDLE.
REQ-012 The baud counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary; no other counter value SHALL cause a bit transition.
REQ-013 Latency SHALL be fixed: with fifo_empty=0 and en=1 sampled in IDLE at cycle N:
- fifo_rd high in cycle N+1
- tx falls at the start of cycle N+3
- frame length (start + d_width data + stop) = (d_width+2)*CLKS_PER_BIT cycles
REQ-014 Back-to-back operation: after STOP returns to IDLE, the next frame SHALL begin per REQ-013, giving an idle-high gap of exactly 3 cycles between frames.
REQ-015 Underflow SHALL be impossible: fifo_rd SHALL never be asserted while fifo_empty=1 was sampled in IDLE.
REQ-016 Deasserting en outside IDLE SHALL NOT abort the frame in progress; the frame SHALL complete and the block SHALL then remain in IDLE.
REQ-017 fifo_data changes outside WAIT SHALL NOT affect tx.
REQ-018 tx SHALL be glitch-free: driven only from a register.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL set:
- state=IDLE
- tx=1, fifo_rd=0, busy=0, tx_done=0
- baud counter=0, bit index=0, shift register=0
REQ-020 Reset asserted mid-frame SHALL abandon the byte: tx=1 from the next cycle, no tx_done, and no further fifo_rd until rst=0 and the REQ-005 conditions hold.
REQ-021 Reset held high SHALL suppress fifo_rd regardless of en or fifo_empty.

Verification (CLKS_PER_BIT=4, d_width=8)
REQ-022 fifo_empty=0, fifo_data=0x55 after the read pulse, en=1 -> fifo_rd high exactly 1 cycle; tx = 0,1,0,1,0,1,0,1,0,1, each level 4 cycles; tx_done pulses once in the 40th frame cycle.
REQ-023 Upstream model holding 0xA3, 0x0F, then going empty -> two frames (LSB first: 1,1,0,0,0,1,0,1 and 1,1,1,1,0,0,0,0); 3-cycle gap between them; exactly 2 fifo_rd pulses; tx high and busy low afterward.
REQ-024 fifo_empty=1, en=1 for 100 cycles -> fifo_rd, busy and tx_done stay 0; tx stays 1.
REQ-025 rst=1 for 1 cycle during the 3rd data bit of byte 0xFF -> tx=1 and busy=0 the next cycle; no tx_done; with fifo_empty still 0, a new fifo_rd follows 1 cycle after rst falls.
REQ-026 en dropped to 0 during the START bit of 0x81 -> full frame 0,1,0,0,0,0,0,0,1,1 is sent; no further fifo_rd while en=0.
REQ-027 fifo_data toggled every cycle except in WAIT -> the transmitted byte equals the value present during WAIT.
